id_stage: RTL and testbench

Instruction-decode stage of the 5-stage MIPS pipeline CPU. It sits directly downstream of IF.
- Latches IF outputs into the IF/ID register.
- Decodes the instruction and reads/writes the 32x32 register file.
- Resolves branches, jumps and jr in ID and drives Z/J/JR/PC_IFWrite/JumpAddr/JrAddr/BranchAddr back to IF.
- Detects load-use and branch hazards, and launches the registered ID/EX bundle to EX.

---
 rtl/id_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_id_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage - instruction-decode stage of the 5-stage MIPS pipeline.
//
// Holds the IF/ID register, decodes the instruction, owns the 32x32
// register file, and resolves beq/bne/j/jr in ID. It also detects
// load-use and branch-operand hazards and drives the registered ID/EX
// bundle to EX.
//
// Optional build macro: BRANCH_BYPASS_EN
//   defined   : branch/jr operands may be forwarded from EX/MEM (non-load).
//   undefined : no EX/MEM forwarding. A branch/jr waits while any EX/MEM
//               writer targets one of its sources, until the value
//               arrives through the write-through port of the register file.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   Instruction_if        fetched instruction from IF
//   NextPC_if             PC+4 from IF
//   IdEx_MemRead_in       feedback of MemRead_ex (load-use detection)
//   ExMem_*               EX/MEM write info, used for bypass and hazards
//   WB_*                  register-file write port
//   Z, J, JR              redirect requests to IF (branch, j, jr)
//   PC_IFWrite            0 stalls the PC and the IF/ID register
//   JumpAddr/JrAddr/BranchAddr  redirect targets
//   *_ex                  registered ID/EX bundle
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned RF_DEPTH  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] NextPC_if,
  input  logic        IdEx_MemRead_in,
  input  logic        ExMem_RegWrite,
  input  logic        ExMem_MemRead,
  input  logic [4:0]  ExMem_WriteReg,
  input  logic [31:0] ExMem_ALUResult,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_Data,
  output logic        Z,
  output logic        J,
  output logic        JR,
  output logic        PC_IFWrite,
  output logic [31:0] JumpAddr,
  output logic [31:0] JrAddr,
  output logic [31:0] BranchAddr,
  output logic        RegWrite_ex,
  output logic        MemRead_ex,
  output logic        MemWrite_ex,
  output logic        MemtoReg_ex,
  output logic        ALUSrcB_ex,
  output logic [2:0]  ALUCode_ex,
  output logic [31:0] RsData_ex,
  output logic [31:0] RtData_ex,
  output logic [31:0] Imm_ex,
  output logic [4:0]  WriteReg_ex,
  output logic [4:0]  Rt_ex
);

  localparam int unsigned AW = $clog2(RF_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_code_t;

  // IF/ID register
  logic [31:0] instr_id;
  logic [31:0] NextPC_id;

  // instruction fields
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sext;

  assign op       = instr_id[31:26];
  assign rs       = instr_id[25:21];
  assign rt       = instr_id[20:16];
  assign rd       = instr_id[15:11];
  assign funct    = instr_id[5:0];
  assign imm_sext = {{16{instr_id[15]}}, instr_id[15:0]};

  // decoded controls
  logic      reg_write, mem_read, mem_write, mem_to_reg, alu_src_b, reg_dst;
  logic      use_rs, use_rt, is_beq, is_bne, is_j, is_jr;
  alu_code_t alu_code;

  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    reg_dst    = 1'b0;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    is_jr      = 1'b0;
    alu_code   = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_write = 1'b1; reg_dst = 1'b1; use_rs = 1'b1; use_rt = 1'b1; alu_code = ALU_ADD; end
          FN_SUB: begin reg_write = 1'b1; reg_dst = 1'b1; use_rs = 1'b1; use_rt = 1'b1; alu_code = ALU_SUB; end
          FN_AND: begin reg_write = 1'b1; reg_dst = 1'b1; use_rs = 1'b1; use_rt = 1'b1; alu_code = ALU_AND; end
          FN_OR:  begin reg_write = 1'b1; reg_dst = 1'b1; use_rs = 1'b1; use_rt = 1'b1; alu_code = ALU_OR;  end
          FN_SLT: begin reg_write = 1'b1; reg_dst = 1'b1; use_rs = 1'b1; use_rt = 1'b1; alu_code = ALU_SLT; end
          FN_JR:  begin is_jr = 1'b1; use_rs = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin reg_write = 1'b1; alu_src_b = 1'b1; use_rs = 1'b1; end
      OP_LW: begin
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src_b  = 1'b1;
        use_rs     = 1'b1;
      end
      OP_SW:  begin mem_write = 1'b1; alu_src_b = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_BEQ: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_BNE: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_J:   is_j = 1'b1;
      default: ;
    endcase
  end

  // register file with write-through reads; r0 reads as zero
  logic [31:0] rf [RF_DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) rf[i[AW-1:0]] <= '0;
    end else if (WB_RegWrite && WB_WriteReg != '0) begin
      rf[WB_WriteReg] <= WB_Data;
    end
  end

  logic [31:0] rs_rf, rt_rf;

  always_comb begin
    rs_rf = '0;
    rt_rf = '0;
    if (rs != '0) rs_rf = (WB_RegWrite && WB_WriteReg == rs) ? WB_Data : rf[rs];
    if (rt != '0) rt_rf = (WB_RegWrite && WB_WriteReg == rt) ? WB_Data : rf[rt];
  end

  // branch/jr operands and EX/MEM hazard term
  logic [31:0] rs_br, rt_br;
  logic        mem_hit_cand;

`ifdef BRANCH_BYPASS_EN
  logic exmem_fwd;
  assign exmem_fwd    = ExMem_RegWrite && !ExMem_MemRead && ExMem_WriteReg != '0;
  assign rs_br        = (exmem_fwd && ExMem_WriteReg == rs) ? ExMem_ALUResult : rs_rf;
  assign rt_br        = (exmem_fwd && ExMem_WriteReg == rt) ? ExMem_ALUResult : rt_rf;
  // only a load in EX/MEM has no value yet
  assign mem_hit_cand = ExMem_MemRead;
`else
  logic unused_exmem;
  assign unused_exmem = ^{ExMem_ALUResult, ExMem_MemRead};
  assign rs_br        = rs_rf;
  assign rt_br        = rt_rf;
  // any EX/MEM writer must reach WB before the branch may read it
  assign mem_hit_cand = ExMem_RegWrite;
`endif

  logic load_use, ex_hit, mem_hit, is_br_src, stall, flush;

  assign load_use  = IdEx_MemRead_in && Rt_ex != '0 &&
                     ((use_rs && Rt_ex == rs) || (use_rt && Rt_ex == rt));
  assign ex_hit    = RegWrite_ex && WriteReg_ex != '0 &&
                     ((use_rs && WriteReg_ex == rs) || (use_rt && WriteReg_ex == rt));
  assign mem_hit   = mem_hit_cand && ExMem_WriteReg != '0 &&
                     ((use_rs && ExMem_WriteReg == rs) || (use_rt && ExMem_WriteReg == rt));
  assign is_br_src = is_beq || is_bne || is_jr;
  assign stall     = load_use || (is_br_src && (ex_hit || mem_hit));

  // redirects are suppressed while stalled, so stall has priority over flush
  assign Z          = !stall && ((is_beq && rs_br == rt_br) || (is_bne && rs_br != rt_br));
  assign J          = !stall && is_j;
  assign JR         = !stall && is_jr;
  assign flush      = Z || J || JR;
  assign PC_IFWrite = !stall;

  assign JumpAddr   = {NextPC_id[31:28], instr_id[25:0], 2'b00};
  assign JrAddr     = rs_br;
  assign BranchAddr = NextPC_id + {imm_sext[29:0], 2'b00};

  // IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_id  <= NOP_INSTR;
      NextPC_id <= '0;
    end else if (!stall) begin
      instr_id  <= flush ? NOP_INSTR : Instruction_if;
      NextPC_id <= NextPC_if;
    end
  end

  // ID/EX register; a stall inserts an all-zero bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || stall) begin
      RegWrite_ex <= 1'b0;
      MemRead_ex  <= 1'b0;
      MemWrite_ex <= 1'b0;
      MemtoReg_ex <= 1'b0;
      ALUSrcB_ex  <= 1'b0;
      ALUCode_ex  <= '0;
      RsData_ex   <= '0;
      RtData_ex   <= '0;
      Imm_ex      <= '0;
      WriteReg_ex <= '0;
      Rt_ex       <= '0;
    end else begin
      RegWrite_ex <= reg_write;
      MemRead_ex  <= mem_read;
      MemWrite_ex <= mem_write;
      MemtoReg_ex <= mem_to_reg;
      ALUSrcB_ex  <= alu_src_b;
      ALUCode_ex  <= alu_code;
      RsData_ex   <= rs_rf;
      RtData_ex   <= rt_rf;
      Imm_ex      <= imm_sext;
      WriteReg_ex <= reg_dst ? rd : rt;
      Rt_ex       <= rt;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction_if, NextPC_if;
  logic        ExMem_RegWrite, ExMem_MemRead;
  logic [4:0]  ExMem_WriteReg;
  logic [31:0] ExMem_ALUResult;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_Data;
  logic        Z, J, JR, PC_IFWrite;
  logic [31:0] JumpAddr, JrAddr, BranchAddr;
  logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrcB_ex;
  logic [2:0]  ALUCode_ex;
  logic [31:0] RsData_ex, RtData_ex, Imm_ex;
  logic [4:0]  WriteReg_ex, Rt_ex;

  int checks = 0;
  int errors = 0;

  id_stage #(.NOP_INSTR(32'h0000_0000), .RF_DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .Instruction_if(Instruction_if), .NextPC_if(NextPC_if),
    .IdEx_MemRead_in(MemRead_ex),
    .ExMem_RegWrite(ExMem_RegWrite), .ExMem_MemRead(ExMem_MemRead),
    .ExMem_WriteReg(ExMem_WriteReg), .ExMem_ALUResult(ExMem_ALUResult),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_Data(WB_Data),
    .Z(Z), .J(J), .JR(JR), .PC_IFWrite(PC_IFWrite),
    .JumpAddr(JumpAddr), .JrAddr(JrAddr), .BranchAddr(BranchAddr),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemtoReg_ex(MemtoReg_ex), .ALUSrcB_ex(ALUSrcB_ex), .ALUCode_ex(ALUCode_ex),
    .RsData_ex(RsData_ex), .RtData_ex(RtData_ex), .Imm_ex(Imm_ex),
    .WriteReg_ex(WriteReg_ex), .Rt_ex(Rt_ex)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_side();
    ExMem_RegWrite = 1'b0; ExMem_MemRead = 1'b0; ExMem_WriteReg = '0; ExMem_ALUResult = '0;
    WB_RegWrite = 1'b0; WB_WriteReg = '0; WB_Data = '0;
  endtask

  task automatic drain();
    Instruction_if = 32'h0; NextPC_if = 32'h0;
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; clear_side();
    Instruction_if = 32'h012A4020; NextPC_if = 32'h4;
    tick(); tick();
    checks++; if (RegWrite_ex !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %0d exp 0", RegWrite_ex); end
    checks++; if ({MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrcB_ex, ALUCode_ex, WriteReg_ex, Rt_ex} !== 12'h000) begin
      errors++; $display("FAIL rst_ctrl got %h exp 000", {MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrcB_ex, ALUCode_ex, WriteReg_ex, Rt_ex}); end
    checks++; if ({RsData_ex, RtData_ex, Imm_ex} !== 96'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {RsData_ex, RtData_ex, Imm_ex}); end
    checks++; if ({PC_IFWrite, Z, J, JR} !== 4'b1000) begin errors++; $display("FAIL rst_redirect got %b exp 1000", {PC_IFWrite, Z, J, JR}); end
  endtask

  task automatic test_writethrough();
    // release: add enters IF/ID on the next edge while WB writes r9
    reset = 1'b1;
    WB_RegWrite = 1'b1; WB_WriteReg = 5'd9; WB_Data = 32'd5;
    tick();
    Instruction_if = 32'h0;
    WB_WriteReg = 5'd10; WB_Data = 32'd7;   // same-cycle write-through for rt
    checks++; if (PC_IFWrite !== 1'b1) begin errors++; $display("FAIL add_nostall got %0d exp 1", PC_IFWrite); end
    tick();
    clear_side();
    checks++; if ({RegWrite_ex, ALUCode_ex, WriteReg_ex} !== {1'b1, 3'd0, 5'd8}) begin
      errors++; $display("FAIL add_decode got %h exp %h", {RegWrite_ex, ALUCode_ex, WriteReg_ex}, {1'b1, 3'd0, 5'd8}); end
    checks++; if (RsData_ex !== 32'd5) begin errors++; $display("FAIL add_rs got %h exp 5", RsData_ex); end
    checks++; if (RtData_ex !== 32'd7) begin errors++; $display("FAIL add_rt_wt got %h exp 7", RtData_ex); end
    // r0 write must not stick nor pass through
    WB_RegWrite = 1'b1; WB_WriteReg = 5'd0; WB_Data = 32'hDEADBEEF;
    Instruction_if = 32'h00005820;          // add r11,r0,r0
    tick();
    Instruction_if = 32'h0;
    tick();
    clear_side();
    checks++; if ({RsData_ex, RtData_ex} !== 64'h0) begin errors++; $display("FAIL r0_read got %h exp 0", {RsData_ex, RtData_ex}); end
    checks++; if (WriteReg_ex !== 5'd11) begin errors++; $display("FAIL r0_dest got %0d exp 11", WriteReg_ex); end
  endtask

  task automatic test_load_use();
    drain();
    Instruction_if = 32'h8C220000;          // lw r2,0(r1)
    tick();
    Instruction_if = 32'h00441820;          // add r3,r2,r4
    tick();
    Instruction_if = 32'h0;
    checks++; if ({MemRead_ex, MemtoReg_ex, ALUSrcB_ex, RegWrite_ex, Rt_ex} !== {4'b1111, 5'd2}) begin
      errors++; $display("FAIL lw_decode got %h exp %h", {MemRead_ex, MemtoReg_ex, ALUSrcB_ex, RegWrite_ex, Rt_ex}, {4'b1111, 5'd2}); end
    checks++; if (PC_IFWrite !== 1'b0) begin errors++; $display("FAIL lu_stall got %0d exp 0", PC_IFWrite); end
    tick();
    checks++; if ({RegWrite_ex, MemRead_ex, WriteReg_ex} !== 7'h0) begin
      errors++; $display("FAIL lu_bubble got %h exp 0", {RegWrite_ex, MemRead_ex, WriteReg_ex}); end
    checks++; if (PC_IFWrite !== 1'b1) begin errors++; $display("FAIL lu_release got %0d exp 1", PC_IFWrite); end
    tick();
    checks++; if ({RegWrite_ex, ALUCode_ex, WriteReg_ex} !== {1'b1, 3'd0, 5'd3}) begin
      errors++; $display("FAIL lu_add_issue got %h exp %h", {RegWrite_ex, ALUCode_ex, WriteReg_ex}, {1'b1, 3'd0, 5'd3}); end
  endtask

  task automatic test_branch();
    drain();
    Instruction_if = 32'h10210003; NextPC_if = 32'h10;   // beq r1,r1,+3
    tick();
    checks++; if ({Z, J, JR, PC_IFWrite} !== 4'b1001) begin errors++; $display("FAIL beq_taken got %b exp 1001", {Z, J, JR, PC_IFWrite}); end
    checks++; if (BranchAddr !== 32'h1C) begin errors++; $display("FAIL beq_target got %h exp 1c", BranchAddr); end
    Instruction_if = 32'h012A4020; NextPC_if = 32'h14;   // must be flushed
    tick();
    Instruction_if = 32'h0;
    checks++; if (Z !== 1'b0) begin errors++; $display("FAIL beq_flush_z got %0d exp 0", Z); end
    checks++; if (RegWrite_ex !== 1'b0) begin errors++; $display("FAIL beq_idex got %0d exp 0", RegWrite_ex); end
    tick();
    checks++; if ({RegWrite_ex, WriteReg_ex} !== 6'h0) begin errors++; $display("FAIL beq_flush_nop got %h exp 0", {RegWrite_ex, WriteReg_ex}); end
    // bne with equal operands: not taken, no flush
    Instruction_if = 32'h14210003; NextPC_if = 32'h20;
    tick();
    checks++; if ({Z, PC_IFWrite} !== 2'b01) begin errors++; $display("FAIL bne_nt got %b exp 01", {Z, PC_IFWrite}); end
    Instruction_if = 32'h012A4020;
    tick();
    Instruction_if = 32'h0;
    tick();
    checks++; if ({RegWrite_ex, WriteReg_ex} !== {1'b1, 5'd8}) begin
      errors++; $display("FAIL bne_noflush got %h exp %h", {RegWrite_ex, WriteReg_ex}, {1'b1, 5'd8}); end
  endtask

  task automatic test_jumps();
    drain();
    Instruction_if = 32'h0800000B; NextPC_if = 32'h30;   // j 0xB
    tick();
    checks++; if ({Z, J, JR} !== 3'b010) begin errors++; $display("FAIL j_taken got %b exp 010", {Z, J, JR}); end
    checks++; if (JumpAddr !== 32'h2C) begin errors++; $display("FAIL j_target got %h exp 2c", JumpAddr); end
    Instruction_if = 32'h012A4020;
    tick();
    Instruction_if = 32'h0;
    checks++; if (J !== 1'b0) begin errors++; $display("FAIL j_flush got %0d exp 0", J); end
    tick();
    checks++; if (RegWrite_ex !== 1'b0) begin errors++; $display("FAIL j_flush_nop got %0d exp 0", RegWrite_ex); end
    // jr r5; r5 written on the same edge jr enters IF/ID
    WB_RegWrite = 1'b1; WB_WriteReg = 5'd5; WB_Data = 32'h34;
    Instruction_if = 32'h00A00008;
    tick();
    clear_side();
    Instruction_if = 32'h0;
    checks++; if ({Z, J, JR} !== 3'b001) begin errors++; $display("FAIL jr_taken got %b exp 001", {Z, J, JR}); end
    checks++; if (JrAddr !== 32'h34) begin errors++; $display("FAIL jr_target got %h exp 34", JrAddr); end
  endtask

  task automatic test_sw();
    drain();
    Instruction_if = 32'hAC27FFFC;          // sw r7,-4(r1)
    tick();
    Instruction_if = 32'h0;
    tick();
    checks++; if ({RegWrite_ex, MemWrite_ex, ALUSrcB_ex, MemRead_ex} !== 4'b0110) begin
      errors++; $display("FAIL sw_ctrl got %b exp 0110", {RegWrite_ex, MemWrite_ex, ALUSrcB_ex, MemRead_ex}); end
    checks++; if (Imm_ex !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_imm got %h exp fffffffc", Imm_ex); end
    checks++; if (Rt_ex !== 5'd7) begin errors++; $display("FAIL sw_rt got %0d exp 7", Rt_ex); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [6];
    logic        exp_rw [6];
    logic [2:0]  exp_alu [6];
    prog = '{32'h012A4022, 32'h012A4024, 32'h012A4025, 32'h012A402A, 32'hFC000000, 32'h012A4021};
    exp_rw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_alu = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    drain();
    for (int i = 0; i <= 6; i++) begin
      Instruction_if = (i < 6) ? prog[i] : 32'h0;
      tick();
      if (i >= 1) begin
        checks++;
        if ({RegWrite_ex, ALUCode_ex} !== {exp_rw[i-1], exp_alu[i-1]}) begin
          errors++; $display("FAIL b2b_%0d got %h exp %h", i - 1, {RegWrite_ex, ALUCode_ex}, {exp_rw[i-1], exp_alu[i-1]}); end
      end
    end
  endtask

  task automatic test_branch_hazard();
    drain();
    Instruction_if = 32'h20060001;          // addi r6,r0,1
    tick();
    Instruction_if = 32'h10C00002; NextPC_if = 32'h40;  // beq r6,r0,+2
    tick();
    Instruction_if = 32'h0;
    checks++; if ({RegWrite_ex, ALUSrcB_ex, WriteReg_ex, Imm_ex} !== {2'b11, 5'd6, 32'd1}) begin
      errors++; $display("FAIL addi_decode got %h exp %h", {RegWrite_ex, ALUSrcB_ex, WriteReg_ex, Imm_ex}, {2'b11, 5'd6, 32'd1}); end
    checks++; if ({PC_IFWrite, Z} !== 2'b00) begin errors++; $display("FAIL bh_stall1 got %b exp 00", {PC_IFWrite, Z}); end
    // addi now in EX/MEM
    ExMem_RegWrite = 1'b1; ExMem_WriteReg = 5'd6; ExMem_ALUResult = 32'd1;
    tick();
    checks++; if (RegWrite_ex !== 1'b0) begin errors++; $display("FAIL bh_bubble got %0d exp 0", RegWrite_ex); end
`ifdef BRANCH_BYPASS_EN
    checks++; if ({PC_IFWrite, Z} !== 2'b10) begin errors++; $display("FAIL bh_bypass got %b exp 10", {PC_IFWrite, Z}); end
    clear_side();
    WB_RegWrite = 1'b1; WB_WriteReg = 5'd6; WB_Data = 32'd1;
    tick();
`else
    checks++; if (PC_IFWrite !== 1'b0) begin errors++; $display("FAIL bh_stall2 got %0d exp 0", PC_IFWrite); end
    // addi now in WB, value arrives via write-through
    clear_side();
    WB_RegWrite = 1'b1; WB_WriteReg = 5'd6; WB_Data = 32'd1;
    #1;
    checks++; if ({PC_IFWrite, Z} !== 2'b10) begin errors++; $display("FAIL bh_wb got %b exp 10", {PC_IFWrite, Z}); end
    tick();
`endif
    clear_side();
  endtask

  task automatic test_reset_mid_stall();
    drain();
    Instruction_if = 32'h012A4020;          // r9 holds 5 from earlier
    tick();
    Instruction_if = 32'h0;
    tick();
    checks++; if (RsData_ex !== 32'd5) begin errors++; $display("FAIL pre_rst_r9 got %h exp 5", RsData_ex); end
    Instruction_if = 32'h8C220000;
    tick();
    Instruction_if = 32'h00441820;
    tick();
    checks++; if (PC_IFWrite !== 1'b0) begin errors++; $display("FAIL mid_stall got %0d exp 0", PC_IFWrite); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({PC_IFWrite, MemRead_ex, RegWrite_ex} !== 3'b100) begin
      errors++; $display("FAIL async_rst got %b exp 100", {PC_IFWrite, MemRead_ex, RegWrite_ex}); end
    Instruction_if = 32'h012A4020;
    tick();
    reset = 1'b1;
    tick();
    Instruction_if = 32'h0;
    tick();
    checks++; if ({RegWrite_ex, RsData_ex} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL rf_cleared got %h exp %h", {RegWrite_ex, RsData_ex}, {1'b1, 32'd0}); end
  endtask

  initial begin
    test_reset();
    test_writethrough();
    test_load_use();
    test_branch();
    test_jumps();
    test_sw();
    test_back_to_back();
    test_branch_hazard();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
